// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and defaults for the pipeline hazard controller.
// Holds the FSM state enum, default watchdog limit / counter width and the
// helper that sizes the watchdog counter from the timeout.
package hazard_pkg;

    localparam int MCU_TIMEOUT_DEF = 64;
    localparam int CNT_W_DEF       = 32;

    // Watchdog must count 0 .. MCU_TIMEOUT-1; never narrower than one bit.
    function automatic int wdog_width(input int timeout);
        return (timeout > 2) ? $clog2(timeout) : 1;
    endfunction

    localparam int WDOG_W_DEF = wdog_width(MCU_TIMEOUT_DEF);

    typedef enum logic {
        RUN      = 1'b0,
        MCU_WAIT = 1'b1
    } state_t;

    // A source operand conflicts only if it is actually read and matches rd.
    function automatic logic src_hit(input logic re, input logic [4:0] ra,
                                     input logic [4:0] wa);
        return re && (ra == wa);
    endfunction

endpackage

// File: rtl/hazard_if.sv
// hazard_if: pipeline-side signals of the hazard controller.
// master = pipeline (drives decode/EX info, receives stalls/flushes),
// slave  = hazard_ctrl.
interface hazard_if
    import hazard_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) ();

    logic [4:0]       rf_ra0_id;
    logic [4:0]       rf_ra1_id;
    logic             rf_re0_id;
    logic             rf_re1_id;
    logic [4:0]       rf_wa_ex;
    logic             rf_we_ex;
    logic             mem_rd_ex;
    logic             br_taken_ex;
    logic             mcu_start_ex;
    logic             mcu_done;

    logic             stall_pc;
    logic             stall_if_id;
    logic             stall_id_ex;
    logic             flush_if_id;
    logic             flush_id_ex;
    logic             flush_ex_mem;
    logic             mcu_go;
    logic             mcu_err;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output rf_ra0_id, rf_ra1_id, rf_re0_id, rf_re1_id,
        output rf_wa_ex, rf_we_ex, mem_rd_ex, br_taken_ex,
        output mcu_start_ex, mcu_done,
        input  stall_pc, stall_if_id, stall_id_ex,
        input  flush_if_id, flush_id_ex, flush_ex_mem,
        input  mcu_go, mcu_err, stall_cnt, flush_cnt
    );

    modport slave (
        input  rf_ra0_id, rf_ra1_id, rf_re0_id, rf_re1_id,
        input  rf_wa_ex, rf_we_ex, mem_rd_ex, br_taken_ex,
        input  mcu_start_ex, mcu_done,
        output stall_pc, stall_if_id, stall_id_ex,
        output flush_if_id, flush_id_ex, flush_ex_mem,
        output mcu_go, mcu_err, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/hazard_perf_cnt.sv
// hazard_perf_cnt: stall/flush cycle counters for the hazard controller.
// Only instantiated when HAZARD_PERF_EN is defined. Counters wrap naturally.
module hazard_perf_cnt
    import hazard_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_any,
    input  logic             flush_any,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    // Count every cycle in which any stall / any flush enable is asserted.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_any) stall_cnt <= stall_cnt + CNT_W'(1);
            if (flush_any) flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use / branch / multi-cycle-op hazard controller for the
// five-stage RV32 pipeline, with a watchdog on the multi-cycle unit.
// Optional feature macro: HAZARD_PERF_EN (stall/flush performance counters;
// when undefined the counter ports are tied to zero).
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MCU_TIMEOUT = MCU_TIMEOUT_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic    clk,
    input  logic    rst,
    hazard_if.slave hz
);

    localparam int                WDOG_W    = wdog_width(MCU_TIMEOUT);
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(MCU_TIMEOUT - 1);

    state_t            state;
    logic [WDOG_W-1:0] wdog;
    logic              mcu_err_q;
    logic              load_use;
    logic              wdog_expired;
    logic              stall_pc;
    logic              stall_if_id;
    logic              stall_id_ex;
    logic              flush_if_id;
    logic              flush_id_ex;
    logic              flush_ex_mem;
    logic              mcu_go;
    logic [CNT_W-1:0]  stall_cnt_q;
    logic [CNT_W-1:0]  flush_cnt_q;

    // Load in EX feeding a source read in ID; x0 is never a hazard source.
    always_comb begin
        load_use = hz.mem_rd_ex && hz.rf_we_ex && (hz.rf_wa_ex != 5'd0) &&
                   (src_hit(hz.rf_re0_id, hz.rf_ra0_id, hz.rf_wa_ex) ||
                    src_hit(hz.rf_re1_id, hz.rf_ra1_id, hz.rf_wa_ex));
        wdog_expired = (wdog == WDOG_LAST);
    end

    // Mealy stall/flush/start decode; a done or timeout cycle releases the freeze.
    always_comb begin
        stall_pc     = 1'b0;
        stall_if_id  = 1'b0;
        stall_id_ex  = 1'b0;
        flush_if_id  = 1'b0;
        flush_id_ex  = 1'b0;
        flush_ex_mem = 1'b0;
        mcu_go       = 1'b0;
        if (!rst) begin
            case (state)
                RUN: begin
                    if (hz.br_taken_ex) begin
                        flush_if_id = 1'b1;
                        flush_id_ex = 1'b1;
                    end else if (hz.mcu_start_ex) begin
                        mcu_go       = 1'b1;
                        stall_pc     = 1'b1;
                        stall_if_id  = 1'b1;
                        stall_id_ex  = 1'b1;
                        flush_ex_mem = 1'b1;
                    end else if (load_use) begin
                        stall_pc    = 1'b1;
                        stall_if_id = 1'b1;
                        flush_id_ex = 1'b1;
                    end
                end
                MCU_WAIT: begin
                    if (!hz.mcu_done && !wdog_expired) begin
                        stall_pc     = 1'b1;
                        stall_if_id  = 1'b1;
                        stall_id_ex  = 1'b1;
                        flush_ex_mem = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Sequencing FSM: RUN <-> MCU_WAIT, watchdog count and sticky error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            wdog      <= '0;
            mcu_err_q <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (!hz.br_taken_ex && hz.mcu_start_ex) begin
                        state <= MCU_WAIT;
                        wdog  <= '0;
                    end
                end
                MCU_WAIT: begin
                    if (hz.mcu_done) begin
                        state <= RUN;
                    end else if (wdog_expired) begin
                        state     <= RUN;
                        mcu_err_q <= 1'b1;
                    end else begin
                        wdog <= wdog + WDOG_W'(1);
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

`ifdef HAZARD_PERF_EN
    logic stall_any;
    logic flush_any;

    // Aggregate enables feeding the performance counters.
    always_comb begin
        stall_any = stall_pc || stall_if_id || stall_id_ex;
        flush_any = flush_if_id || flush_id_ex || flush_ex_mem;
    end

    hazard_perf_cnt #(
        .CNT_W (CNT_W)
    ) u_perf (
        .clk       (clk),
        .rst       (rst),
        .stall_any (stall_any),
        .flush_any (flush_any),
        .stall_cnt (stall_cnt_q),
        .flush_cnt (flush_cnt_q)
    );
`else
    assign stall_cnt_q = '0;
    assign flush_cnt_q = '0;
`endif

    assign hz.stall_pc     = stall_pc;
    assign hz.stall_if_id  = stall_if_id;
    assign hz.stall_id_ex  = stall_id_ex;
    assign hz.flush_if_id  = flush_if_id;
    assign hz.flush_id_ex  = flush_id_ex;
    assign hz.flush_ex_mem = flush_ex_mem;
    assign hz.mcu_go       = mcu_go;
    assign hz.mcu_err      = mcu_err_q;
    assign hz.stall_cnt    = stall_cnt_q;
    assign hz.flush_cnt    = flush_cnt_q;

endmodule
